// File: rtl/fetch_pkg.sv
// Shared constants and FSM state encoding for the instruction fetch stage.
package fetch_pkg;

    localparam int IF_XLEN  = 64;
    localparam int IF_INS_W = 32;
    localparam int PC_INC   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus plus the IF/ID output bus of the fetch stage.
// The fetch stage is the master; memory and decode sit on the slave side.
interface instruction_fetch_if #(
    parameter int XLEN  = 64,
    parameter int INS_W = 32
);

    logic             imem_req;
    logic [XLEN-1:0]  imem_addr;
    logic             imem_ready;
    logic             imem_rvalid;
    logic [INS_W-1:0] imem_rdata;

    logic             id_valid;
    logic             id_ready;
    logic [XLEN-1:0]  id_pc;
    logic [INS_W-1:0] id_ins;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata,
        output id_valid,
        input  id_ready,
        output id_pc,
        output id_ins
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata,
        input  id_valid,
        output id_ready,
        input  id_pc,
        input  id_ins
    );

endinterface

// File: rtl/if_id_reg.sv
// Single-entry IF/ID pipeline register with valid/ready handshake and flush.
// A flush wins over a load; a load wins over a dequeue in the same cycle.
module if_id_reg #(
    parameter int XLEN  = 64,
    parameter int INS_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             flush_i,
    input  logic             ready_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [INS_W-1:0] ins_i,
    output logic             valid_o,
    output logic [XLEN-1:0]  pc_o,
    output logic [INS_W-1:0] ins_o
);

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [INS_W-1:0] ins_q, ins_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ins_d   = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            ins_d   = ins_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            ins_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign ins_o   = ins_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC and a one-outstanding-request FSM towards instruction memory,
// and fills the IF/ID register. Taken branches redirect the PC and squash in-flight fetches.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int              XLEN     = IF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              INS_W    = IF_INS_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                branch_taken,
    input  logic [XLEN-1:0]     branch_target,
    instruction_fetch_if.master bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            drop_q, drop_d;

    logic            slot_free;
    logic            req_fire;
    logic            load;
    logic            flush;
    logic [XLEN-1:0] branch_pc;
    logic            unused_target_lsb;

    assign branch_pc         = {branch_target[XLEN-1:2], 2'b00};
    assign unused_target_lsb = ^branch_target[1:0];

    // Requests only go out when the IF/ID slot will be empty by the time data returns.
    assign slot_free     = !bus.id_valid || bus.id_ready;
    assign bus.imem_req  = (state_q == FETCH) && slot_free;
    assign bus.imem_addr = pc_q;
    assign req_fire      = bus.imem_req && bus.imem_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        load     = 1'b0;
        flush    = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (req_fire) begin
                    state_d  = WAIT;
                    req_pc_d = pc_q;
                    drop_d   = 1'b0;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    state_d = FETCH;
                    drop_d  = 1'b0;
                    if (!drop_q) begin
                        load = 1'b1;
                        pc_d = req_pc_q + XLEN'(PC_INC);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A redirect overrides any load; a request still in flight must have its data dropped.
        if (branch_taken) begin
            pc_d   = branch_pc;
            flush  = 1'b1;
            load   = 1'b0;
            drop_d = ((state_q == WAIT) && !bus.imem_rvalid) ||
                     ((state_q == FETCH) && req_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
        end
    end

    if_id_reg #(
        .XLEN  (XLEN),
        .INS_W (INS_W)
    ) u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .flush_i (flush),
        .ready_i (bus.id_ready),
        .pc_i    (req_pc_q),
        .ins_i   (bus.imem_rdata),
        .valid_o (bus.id_valid),
        .pc_o    (bus.id_pc),
        .ins_o   (bus.id_ins)
    );

endmodule
